// File: rtl/conv2_kernel_fetch.sv
// conv2_kernel_fetch: streams weight pairs from the dual-port kernel ROM through a 2-entry skid FIFO
module conv2_kernel_fetch #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16,
  parameter int LEN_W  = 9
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  length,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rom_addr_a,
  output logic [ADDR_W-1:0] rom_addr_b,
  input  logic [DATA_W-1:0] rom_q_a,
  input  logic [DATA_W-1:0] rom_q_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_w0,
  output logic [DATA_W-1:0] out_w1,
  output logic              out_w1_valid,
  output logic              out_last
);
  localparam int EW = 2*DATA_W + 2;
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;
  state_t state, state_nx;
  logic [ADDR_W-1:0] base_r, idx, addr_a;
  logic [LEN_W-1:0] len_r, npairs;
  logic tag_v, tag_w1v, tag_last;
  logic [EW-1:0] mem [2];
  logic [EW-1:0] head;
  logic wp, rp, push, pop, issue, is_last, w1v, accept;
  logic [1:0] cnt, credits;
  assign accept = state == IDLE && start && length != '0;
  assign npairs = (len_r + LEN_W'(1)) >> 1;
  assign is_last = LEN_W'(idx) == npairs - LEN_W'(1);
  assign w1v = LEN_W'({idx, 1'b1}) < len_r;
  assign credits = cnt + {1'b0, tag_v};
  assign head = mem[rp];
  assign out_valid = cnt != 2'd0;
  assign pop = out_valid & out_ready;
  assign push = tag_v;
  // a pop in the same cycle frees the credit this issue needs
  assign issue = state == FETCH && (credits < 2'd2 || pop);
  assign busy = state != IDLE;
  assign addr_a = base_r + {idx[ADDR_W-2:0], 1'b0};
  assign rom_addr_a = busy ? addr_a : '0;
  assign rom_addr_b = busy ? addr_a + ADDR_W'(1) : '0;
  assign out_w0 = out_valid ? head[DATA_W+2 +: DATA_W] : '0;
  assign out_w1 = out_valid ? head[2 +: DATA_W] : '0;
  assign out_w1_valid = out_valid & head[1];
  assign out_last = out_valid & head[0];
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = accept ? FETCH : IDLE;
      FETCH:   state_nx = issue && is_last ? DRAIN : FETCH;
      DRAIN:   state_nx = pop && head[0] ? IDLE : DRAIN;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      base_r <= '0;
      len_r <= '0;
      idx <= '0;
      tag_v <= 1'b0;
      tag_w1v <= 1'b0;
      tag_last <= 1'b0;
      wp <= 1'b0;
      rp <= 1'b0;
      cnt <= 2'd0;
      done <= 1'b0;
      mem[0] <= '0;
      mem[1] <= '0;
    end else begin
      done <= (state == IDLE && start && length == '0) || (pop && head[0]);
      if (accept) begin
        base_r <= base_addr;
        len_r <= length;
        idx <= '0;
      end else if (issue && !is_last) idx <= idx + ADDR_W'(1);
      tag_v <= issue;
      if (issue) begin
        tag_w1v <= w1v;
        tag_last <= is_last;
      end
      if (push) mem[wp] <= {rom_q_a, tag_w1v ? rom_q_b : '0, tag_w1v, tag_last};
      wp <= wp ^ push;
      rp <= rp ^ pop;
      cnt <= cnt + {1'b0, push} - {1'b0, pop};
    end
  end
endmodule

// File: tb/tb_conv2_kernel_fetch.sv
// tb_conv2_kernel_fetch: scoreboard bench for conv2_kernel_fetch against a rom[i]=i*3 model
module tb_conv2_kernel_fetch;
  typedef logic [33:0] pair_t;
  logic clock = 1'b0, reset_n = 1'b0, start = 1'b0, out_ready = 1'b0;
  logic [7:0] base_addr = '0;
  logic [8:0] length = '0;
  logic busy, done, out_valid, out_w1_valid, out_last;
  logic [7:0] rom_addr_a, rom_addr_b;
  logic [15:0] rom_q_a, rom_q_b, out_w0, out_w1;
  int errors = 0, checks = 0;
  int npairs, first_v, done_c, last_pop, vcyc;
  pair_t last_pair;
  pair_t exp_q[$];

  conv2_kernel_fetch dut (
    .clock(clock), .reset_n(reset_n), .start(start), .base_addr(base_addr), .length(length),
    .busy(busy), .done(done), .rom_addr_a(rom_addr_a), .rom_addr_b(rom_addr_b),
    .rom_q_a(rom_q_a), .rom_q_b(rom_q_b), .out_valid(out_valid), .out_ready(out_ready),
    .out_w0(out_w0), .out_w1(out_w1), .out_w1_valid(out_w1_valid), .out_last(out_last)
  );

  always #5 clock = ~clock;

  function automatic logic [15:0] romv(input logic [7:0] a);
    return 16'(a) * 16'd3;
  endfunction

  always @(posedge clock) begin
    rom_q_a <= romv(rom_addr_a);
    rom_q_b <= romv(rom_addr_b);
  end

  task automatic run_req(input logic [7:0] b, input logic [8:0] n, input bit rnd, input int poke, input int abort_after);
    int np, cyc;
    logic [7:0] a;
    bit v, stall, aborted;
    pair_t cur, prev, e;
    np = (int'(n) + 1) / 2;
    for (int p = 0; p < np; p++) begin
      a = b + 8'(2*p);
      v = (2*p + 1) < int'(n);
      exp_q.push_back({romv(a), v ? romv(a + 8'd1) : 16'd0, v, p == np - 1});
    end
    npairs = 0; first_v = -1; done_c = -1; last_pop = -1; vcyc = 0;
    stall = 0; aborted = 0; prev = '0;
    base_addr = b; length = n; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0; base_addr = 8'hAA; length = 9'd3;
    for (cyc = 0; cyc < 300; cyc++) begin
      out_ready = !rnd ? 1'b1 : (cyc >= 4 && cyc < 9) ? 1'b0 : 1'($urandom_range(0, 1));
      start = cyc == poke;
      if (cyc == poke) begin base_addr = 8'h77; length = 9'd100; end
      @(negedge clock);
      cur = {out_w0, out_w1, out_w1_valid, out_last};
      if (stall) begin
        checks++;
        if (!out_valid || cur !== prev) begin
          errors++;
          $display("FAIL stall_hold cyc=%0d got=%h valid=%b want=%h", cyc, cur, out_valid, prev);
        end
      end
      if (out_valid) begin
        vcyc++;
        if (first_v < 0) first_v = cyc;
      end
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL extra_pair cyc=%0d got=%h want=none", cyc, cur);
        end else begin
          e = exp_q.pop_front();
          if (cur !== e) begin
            errors++;
            $display("FAIL pair cyc=%0d got=%h want=%h", cyc, cur, e);
          end
        end
        npairs++; last_pop = cyc; last_pair = cur;
      end
      stall = out_valid && !out_ready;
      prev = cur;
      checks++;
      if (busy !== (n != 0 && !done)) begin
        errors++;
        $display("FAIL busy cyc=%0d got=%b want=%b", cyc, busy, n != 0 && !done);
      end
      if (done) begin done_c = cyc; break; end
      if (abort_after >= 0 && npairs == abort_after) begin
        reset_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, out_valid, out_last, out_w1_valid, out_w0, out_w1, rom_addr_a, rom_addr_b} !== '0) begin
          errors++;
          $display("FAIL abort_zero got=%b%b%b%b%b %h %h %h %h want=all 0", busy, done, out_valid,
                   out_last, out_w1_valid, out_w0, out_w1, rom_addr_a, rom_addr_b);
        end
        aborted = 1;
        break;
      end
      @(posedge clock); #1;
    end
    start = 1'b0;
    if (!aborted) begin
      checks++;
      if (done_c < 0 || exp_q.size() != 0) begin
        errors++;
        $display("FAIL completion done_cyc=%0d missing=%0d want done and 0 missing", done_c, exp_q.size());
      end
      @(posedge clock); #1;
      @(negedge clock);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL done_pulse got done=%b busy=%b want 0 0", done, busy);
      end
      @(posedge clock); #1;
    end
    exp_q.delete();
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if ({busy, done, out_valid, out_last, out_w1_valid, out_w0, out_w1, rom_addr_a, rom_addr_b} !== '0) begin
      errors++;
      $display("FAIL reset_state got busy=%b done=%b valid=%b w0=%h w1=%h a=%h b=%h want all 0",
               busy, done, out_valid, out_w0, out_w1, rom_addr_a, rom_addr_b);
    end
    reset_n = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic test_basic;
    run_req(8'h10, 9'd4, 0, -1, -1);
    checks++;
    if (npairs != 2) begin errors++; $display("FAIL basic_count got=%0d want=2", npairs); end
    checks++;
    if (first_v != 2) begin errors++; $display("FAIL basic_latency got=%0d want=2", first_v); end
    checks++;
    if (done_c != last_pop + 1) begin errors++; $display("FAIL basic_done_cyc got=%0d want=%0d", done_c, last_pop + 1); end
    checks++;
    if (last_pair !== {16'h0036, 16'h0039, 1'b1, 1'b1}) begin
      errors++; $display("FAIL basic_last got=%h want=%h", last_pair, {16'h0036, 16'h0039, 1'b1, 1'b1});
    end
    checks++;
    if (rom_addr_a !== 8'h00 || rom_addr_b !== 8'h00) begin
      errors++; $display("FAIL idle_addr got=%h/%h want=00/00", rom_addr_a, rom_addr_b);
    end
  endtask

  task automatic test_odd;
    run_req(8'h20, 9'd5, 0, -1, -1);
    checks++;
    if (npairs != 3) begin errors++; $display("FAIL odd_count got=%0d want=3", npairs); end
    checks++;
    if (last_pair !== {16'h006C, 16'h0000, 1'b0, 1'b1}) begin
      errors++; $display("FAIL odd_last got=%h want=%h", last_pair, {16'h006C, 16'h0000, 1'b0, 1'b1});
    end
  endtask

  task automatic test_back_to_back;
    run_req(8'h00, 9'd16, 1, -1, -1);
    checks++;
    if (npairs != 8) begin errors++; $display("FAIL stall_count got=%0d want=8", npairs); end
    run_req(8'h00, 9'd16, 0, -1, -1);
    checks++;
    if (vcyc != 8 || last_pop - first_v != 7) begin
      errors++; $display("FAIL stream_rate got valid=%0d span=%0d want 8 and 7", vcyc, last_pop - first_v);
    end
  endtask

  task automatic test_wrap;
    run_req(8'hFE, 9'd4, 0, -1, -1);
    checks++;
    if (last_pair !== {16'h0000, 16'h0003, 1'b1, 1'b1}) begin
      errors++; $display("FAIL wrap_last got=%h want=%h", last_pair, {16'h0000, 16'h0003, 1'b1, 1'b1});
    end
  endtask

  task automatic test_zero_and_ignore;
    run_req(8'h33, 9'd0, 0, -1, -1);
    checks++;
    if (done_c != 0 || vcyc != 0) begin
      errors++; $display("FAIL zero_len got done_cyc=%0d valid=%0d want 0 and 0", done_c, vcyc);
    end
    run_req(8'h50, 9'd8, 1, 1, -1);
    checks++;
    if (npairs != 4) begin errors++; $display("FAIL ignore_start got=%0d want=4", npairs); end
  endtask

  task automatic test_abort;
    run_req(8'h30, 9'd10, 0, -1, 2);
    @(posedge clock); #1;
    reset_n = 1'b1;
    @(posedge clock); #1;
    run_req(8'h40, 9'd2, 0, -1, -1);
    checks++;
    if (npairs != 1 || last_pair !== {16'h00C0, 16'h00C3, 1'b1, 1'b1}) begin
      errors++; $display("FAIL post_abort got n=%0d pair=%h want 1 and %h", npairs, last_pair,
                         {16'h00C0, 16'h00C3, 1'b1, 1'b1});
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_odd();
    test_back_to_back();
    test_wrap();
    test_zero_and_ignore();
    test_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/conv2_kernel_fetch.md
Name: conv2_kernel_fetch

Overview:
Read-side sequencer for the conv2 kernel-weight ROMs. These are 256 x 16-bit dual-port memories with registered outputs and 1-cycle read latency. Given a base address and a word count, the block drives both ROM address ports to fetch two consecutive weights per cycle, absorbs the ROM latency in a 2-entry skid FIFO, and streams weight pairs to the conv2 MAC array over a valid/ready handshake.

Parameters:
ADDR_W, 8, ROM address width; addresses wrap modulo 2^ADDR_W.
DATA_W, 16, weight word width.
LEN_W, 9, width of the length input; lengths run 0..2^ADDR_W.

Ports:
clock  in  1  system clock, rising edge.
reset_n  in  1  asynchronous active-low reset.
start  in  1  single-cycle request; sampled only in IDLE.
base_addr  in  ADDR_W  first ROM word address; sampled with start.
length  in  LEN_W  number of weights to fetch; sampled with start.
busy  out  1  high from the start-accept edge until the done pulse.
done  out  1  one-cycle pulse after the final pair is popped.
rom_addr_a  out  ADDR_W  to ROM address_a; combinational from internal state.
rom_addr_b  out  ADDR_W  to ROM address_b; combinational from internal state.
rom_q_a  in  DATA_W  from ROM q_a; valid one edge after the address.
rom_q_b  in  DATA_W  from ROM q_b.
out_valid  out  1  pair available.
out_ready  in  1  consumer accepts the pair.
out_w0  out  DATA_W  weight at the even offset.
out_w1  out  DATA_W  weight at the odd offset; 0 when out_w1_valid=0.
out_w1_valid  out  1  out_w1 carries a real weight.
out_last  out  1  this is the final pair of the request.

Behaviour:
- Reset (asynchronous, reset_n low): state IDLE; busy=0, done=0, out_valid=0, out_last=0, out_w1_valid=0, out_w0=0, out_w1=0; FIFO empty; in-flight tag cleared; pair index=0.
  - rom_addr_a/b are 0 in IDLE (base register resets to 0).
  - Mid-request reset aborts the request with no done pulse. The stale ROM q is ignored because the in-flight tag is cleared.
- States: IDLE, FETCH, DRAIN.
- IDLE:
  - start=1 with length>0: latch base and length, index=0, go to FETCH, busy=1.
  - start=1 with length=0: stay IDLE; done=1 the next cycle; busy stays 0; no out_valid.
- FETCH:
  - rom_addr_a = base+2*index, rom_addr_b = base+2*index+1, both truncated to ADDR_W (wrap-around).
  - A pair is issued in a cycle when credits<2, or when a FIFO pop occurs in the same cycle.
  - credits = FIFO occupancy + in-flight tag; each issue consumes one credit, each pop frees one.
  - On issue: index++. Set the in-flight tag, carrying last = (this is pair ceil(length/2)-1) and w1v = (2*index+1 < length).
  - After the last pair is issued, go to DRAIN.
- In-flight tag: registered. On the edge after issue, push {rom_q_a, w1v ? rom_q_b : 0, w1v, last} into the FIFO.
- DRAIN: no issue; addresses hold their final values. When the pair with last=1 is popped, go to IDLE, busy=0, done=1 for one cycle.
- start during FETCH/DRAIN: ignored, with no effect on the latched parameters.
- FIFO: 2 entries. The output is the head entry; out_valid = FIFO non-empty. Pop = out_valid & out_ready.
  - Outputs are stable while out_valid=1 and out_ready=0.
  - Push and pop in the same cycle is legal. Overflow is impossible by the credit rule.
- Latency: start sampled at edge E0, first address presented in the following cycle, ROM registers at E1, FIFO captures at E2. out_valid first rises after E2.
- Throughput: one pair per cycle with out_ready held high. A fetch of N words delivers ceil(N/2) pairs.
- out_ready may be high while out_valid=0; it has no effect.
- Odd length: the final pair has out_w1_valid=0 and out_w1=0. rom_addr_b is still driven (base+length, wrapped) and its data is discarded.
- length > 2^ADDR_W is illegal and not checked.

Test Plan:
- ROM model rom[i]=i*3, base=0x10, length=4, out_ready=1 -> pairs (0x30,0x33,last=0), (0x36,0x39,last=1). out_valid first rises 2 edges after start. done pulses 1 cycle after the last pop; busy is high throughout.
- base=0x20, length=5 -> 3 pairs; the third is out_w0=0x6C, out_w1=0, out_w1_valid=0, out_last=1.
- base=0x00, length=16, out_ready toggled 0/1 pseudo-randomly (including low for 5 cycles) -> exactly 8 pairs in order, no loss or duplication, outputs stable while stalled. With ready held high, 8 consecutive valid cycles.
- base=0xFE, length=4 -> addresses issued (FE,FF) then (00,01); pairs (0x2FA,0x2FD), (0x000,0x003).
- length=0 start -> done=1 the next cycle, busy=0, out_valid never asserted. A start pulsed during an active length=8 request -> ignored; exactly 4 pairs are delivered.
- reset_n driven low mid-request (after 2 pairs) -> all outputs 0 immediately. A following start with base=0x40, length=2 -> single pair (0xC0,0xC3,last=1) with no stale data ahead of it.
